// File: rtl/pru_fifo_pkg.sv
// Shared types and constants for the PRU clock-crossing FIFO packet framer.
package pru_fifo_pkg;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, TRAIL} pkt_wr_state_t;

  localparam logic [3:0]  HDR_TAG   = 4'hA;
  localparam int unsigned PKT_WIDTH = 16;
  localparam int unsigned PKT_LEN_W = 8;

  // Header word for the default geometry: tag in the top nibble, length in the low bits.
  function automatic logic [PKT_WIDTH-1:0] mk_hdr(input logic [PKT_LEN_W-1:0] len);
    return {HDR_TAG, (PKT_WIDTH-PKT_LEN_W-4)'(0), len};
  endfunction

endpackage

// File: rtl/fifo_pkt_writer.sv
// Write-side framer: header, N payload words and an XOR trailer into the async FIFO.
module fifo_pkt_writer
  import pru_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = PKT_WIDTH,
  parameter int unsigned LEN_W = PKT_LEN_W
) (
  input  logic             i_wclk,
  input  logic             i_wrst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_fifo_wr,
  output logic [WIDTH-1:0] o_fifo_wdata,
  input  logic             i_fifo_full
);

  pkt_wr_state_t    state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] csum_q, csum_d;
  logic             done_d, err_d;
  logic [WIDTH-1:0] hdr;

  // Generic header build so any WIDTH >= LEN_W + 4 works without a zero-width pad.
  assign hdr = (WIDTH'(HDR_TAG) << (WIDTH - 4)) | WIDTH'(len_q);

  // Next-state, datapath updates and the pass-through FIFO write port.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    count_d      = count_q;
    csum_d       = csum_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    o_busy       = (state_q != IDLE);
    o_ready      = 1'b0;
    o_fifo_wr    = 1'b0;
    o_fifo_wdata = hdr;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            len_d   = i_len;
            count_d = '0;
            csum_d  = '0;
            state_d = HDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HDR: begin
        o_fifo_wr = ~i_fifo_full;
        if (!i_fifo_full) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        o_ready      = ~i_fifo_full;
        o_fifo_wr    = i_valid & ~i_fifo_full;
        o_fifo_wdata = i_data;
        if (i_valid && !i_fifo_full) begin
          csum_d  = csum_q ^ i_data;
          count_d = count_q + LEN_W'(1);
          if (count_q == LEN_W'(len_q - LEN_W'(1))) state_d = TRAIL;
        end
      end
      TRAIL: begin
        o_fifo_wr    = ~i_fifo_full;
        o_fifo_wdata = csum_q;
        if (!i_fifo_full) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      csum_q  <= '0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      o_done  <= done_d;
      o_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Scoreboard bench for fifo_pkt_writer: stimulus pushes expected FIFO words, a monitor pops them.
module tb_fifo_pkt_writer;

  typedef struct {
    logic [15:0] word;
    bit          last;
  } exp_t;

  logic        i_wclk = 1'b0;
  logic        i_wrst_n;
  logic        i_start;
  logic [7:0]  i_len;
  logic        i_valid;
  logic [15:0] i_data;
  logic        o_ready, o_busy, o_done, o_err, o_fifo_wr;
  logic [15:0] o_fifo_wdata;
  logic        i_fifo_full;

  logic        full_man = 1'b0;
  logic        full_rnd = 1'b0;
  logic        rand_en  = 1'b0;
  assign i_fifo_full = full_man | (rand_en & full_rnd);

  exp_t        sb[$];
  logic [15:0] pd[0:255];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          done_pend = 1'b0;

  fifo_pkt_writer #(.WIDTH(16), .LEN_W(8)) dut (
    .i_wclk(i_wclk), .i_wrst_n(i_wrst_n), .i_start(i_start), .i_len(i_len),
    .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_fifo_wr(o_fifo_wr),
    .o_fifo_wdata(o_fifo_wdata), .i_fifo_full(i_fifo_full)
  );

  always #5 i_wclk = ~i_wclk;

  always @(posedge i_wclk) begin
    #1 full_rnd = ($urandom_range(0, 3) == 0);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h required 0x%04h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expected word per FIFO write and tracks the done pulse.
  always @(negedge i_wclk) begin
    if (!i_wrst_n) begin
      done_pend = 1'b0;
    end else begin
      chk("o_done", 16'(o_done), 16'(done_pend));
      done_pend = 1'b0;
      if (i_fifo_full) begin
        chk("wr_while_full", 16'(o_fifo_wr), 16'h0);
        chk("ready_while_full", 16'(o_ready), 16'h0);
      end
      if (o_fifo_wr) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", o_fifo_wdata, 16'hxxxx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("fifo_wdata", o_fifo_wdata, e.word);
          done_pend = e.last;
        end
      end
    end
  end

  task automatic push(input logic [15:0] w, input bit last);
    exp_t e;
    e.word = w;
    e.last = last;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle o_done is high.
  task automatic send_pkt(input int len, input int gap, input bit rnd_gap,
                          input int stall_after, input bit poke, input logic [15:0] trl);
    bit acc;
    int tmo;
    int g;
    i_start = 1'b1;
    i_len   = 8'(len);
    push(16'hA000 | 16'(len), 1'b0);
    for (int i = 0; i < len; i++) push(pd[i], 1'b0);
    push(trl, 1'b1);
    @(posedge i_wclk); #1;
    i_start = 1'b0;
    @(negedge i_wclk);
    chk("hdr_busy", 16'(o_busy), 16'h1);
    if (!i_fifo_full) chk("hdr_write", 16'(o_fifo_wr), 16'h1);
    @(posedge i_wclk); #1;
    for (int i = 0; i < len; i++) begin
      g = rnd_gap ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap);
      for (int k = 0; k < g; k++) begin
        if (poke && i == 1 && k == 0) begin
          i_start = 1'b1;
          i_len   = 8'd5;
        end
        @(posedge i_wclk); #1;
        i_start = 1'b0;
      end
      i_valid = 1'b1;
      i_data  = pd[i];
      acc = 1'b0;
      tmo = 0;
      while (!acc) begin
        @(negedge i_wclk);
        acc = o_ready;
        @(posedge i_wclk); #1;
        if (++tmo > 1000) begin
          chk("accept_timeout", 16'h1, 16'h0);
          acc = 1'b1;
        end
      end
      i_valid = 1'b0;
      if (i == stall_after) begin
        full_man = 1'b1;
        i_valid  = 1'b1;
        i_data   = pd[i+1];
        repeat (4) begin
          @(posedge i_wclk); #1;
        end
        full_man = 1'b0;
        i_valid  = 1'b0;
      end
    end
    tmo = 0;
    while (o_done !== 1'b1) begin
      @(posedge i_wclk); #1;
      if (++tmo > 1000) begin
        chk("done_timeout", 16'h1, 16'h0);
        break;
      end
    end
  endtask

  initial begin
    logic [15:0] x;
    bit acc;
    int tmo;
    i_wrst_n = 1'b0;
    i_start  = 1'b0;
    i_len    = '0;
    i_valid  = 1'b0;
    i_data   = '0;
    #3;
    chk("rst_busy", 16'(o_busy), 16'h0);
    chk("rst_ready", 16'(o_ready), 16'h0);
    chk("rst_wr", 16'(o_fifo_wr), 16'h0);
    chk("rst_done", 16'(o_done), 16'h0);
    chk("rst_err", 16'(o_err), 16'h0);
    @(posedge i_wclk); #1;
    i_wrst_n = 1'b1;
    @(posedge i_wclk); #1;

    // 1: basic packet
    pd[0] = 16'h1111; pd[1] = 16'h2222; pd[2] = 16'h4444;
    send_pkt(3, 0, 1'b0, -1, 1'b0, 16'h7777);
    repeat (2) @(posedge i_wclk); #1;

    // 2: four-cycle full stall after the second payload word
    send_pkt(3, 0, 1'b0, 1, 1'b0, 16'h7777);
    repeat (2) @(posedge i_wclk); #1;

    // 3: producer gaps of three cycles
    pd[0] = 16'h0F0F; pd[1] = 16'h3C3C;
    send_pkt(2, 3, 1'b0, -1, 1'b0, 16'h3333);
    repeat (2) @(posedge i_wclk); #1;

    // 4: zero-length request, then a start while busy
    i_start = 1'b1;
    i_len   = 8'd0;
    @(negedge i_wclk);
    chk("err_early", 16'(o_err), 16'h0);
    @(posedge i_wclk); #1;
    i_start = 1'b0;
    @(negedge i_wclk);
    chk("err_pulse", 16'(o_err), 16'h1);
    chk("err_busy", 16'(o_busy), 16'h0);
    chk("err_no_wr", 16'(o_fifo_wr), 16'h0);
    @(posedge i_wclk); #1;
    @(negedge i_wclk);
    chk("err_one_cycle", 16'(o_err), 16'h0);
    @(posedge i_wclk); #1;
    pd[0] = 16'h00FF; pd[1] = 16'hFF00;
    send_pkt(2, 2, 1'b0, -1, 1'b1, 16'hFFFF);
    repeat (2) @(posedge i_wclk); #1;

    // 5: reset after one of four payload words
    i_start = 1'b1;
    i_len   = 8'd4;
    push(16'hA004, 1'b0);
    push(16'h1234, 1'b0);
    @(posedge i_wclk); #1;
    i_start = 1'b0;
    i_valid = 1'b1;
    i_data  = 16'h1234;
    acc = 1'b0;
    tmo = 0;
    while (!acc) begin
      @(negedge i_wclk);
      acc = o_ready;
      @(posedge i_wclk); #1;
      if (++tmo > 100) begin
        chk("rst_accept_timeout", 16'h1, 16'h0);
        acc = 1'b1;
      end
    end
    i_data = 16'h5678;
    chk("mid_busy", 16'(o_busy), 16'h1);
    i_wrst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 16'(o_busy), 16'h0);
    chk("rst_mid_wr", 16'(o_fifo_wr), 16'h0);
    chk("rst_mid_ready", 16'(o_ready), 16'h0);
    i_valid = 1'b0;
    @(posedge i_wclk); #1;
    i_wrst_n = 1'b1;
    chk("rst_sb_drained", 16'(sb.size()), 16'h0);
    @(posedge i_wclk); #1;
    pd[0] = 16'hBEEF;
    send_pkt(1, 0, 1'b0, -1, 1'b0, 16'hBEEF);
    repeat (2) @(posedge i_wclk); #1;

    // 6: max length with random full/valid, then back-to-back start in the done cycle
    x = '0;
    for (int i = 0; i < 255; i++) begin
      pd[i] = 16'(i * 257) ^ 16'h5A3C;
      x ^= pd[i];
    end
    rand_en = 1'b1;
    send_pkt(255, 0, 1'b1, -1, 1'b0, x);
    pd[0] = 16'hC0DE;
    send_pkt(1, 0, 1'b0, -1, 1'b0, 16'hC0DE);
    rand_en = 1'b0;
    repeat (3) @(posedge i_wclk); #1;

    chk("sb_empty", 16'(sb.size()), 16'h0);
    chk("idle_at_end", 16'(o_busy), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
